filter_data_sink: RTL and testbench

Receiving end of the filter output interface. Captures every DOUT sample the IIR filter qualifies with VOUT into an on-chip FIFO, and lets a downstream reader (output file writer, checker or host port) drain it at its own pace. It tracks accepted samples, flags dropped samples, and signals end-of-stream completion once END_SIM is seen and the buffer is empty. It sits between the IIR_filter DOUT/VOUT pins and the output sink.

---
 rtl/filter_io_pkg.sv | 15 +
 rtl/sink_fifo_mem.sv | 44 ++++
 rtl/filter_data_sink.sv | 144 ++++++++++++++
 tb/tb_filter_data_sink.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/filter_io_pkg.sv
// Shared definitions for the filter output interface: default widths and
// the sink control states.
package filter_io_pkg;

    localparam int NB_DEFAULT         = 10;
    localparam int DEPTH_LOG2_DEFAULT = 4;
    localparam int CNT_W_DEFAULT      = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        FINISH = 2'd2
    } sinkState_e;

endpackage

// File: rtl/sink_fifo_mem.sv
// Sample storage for the data sink: a plain register array with one
// synchronous write port and one registered read port. The array itself
// carries no reset; only the read data register is cleared so the sink
// output starts at zero.
module sink_fifo_mem
    import filter_io_pkg::*;
#(
    parameter int Nb         = NB_DEFAULT,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rstN_i,
    input  logic                  wrEn_i,
    input  logic [DEPTH_LOG2-1:0] wrAddr_i,
    input  logic [Nb-1:0]         wrData_i,
    input  logic                  rdEn_i,
    input  logic [DEPTH_LOG2-1:0] rdAddr_i,
    output logic [Nb-1:0]         rdData_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [Nb-1:0] mem_q [DEPTH];
    logic [Nb-1:0] rdData_q;

    // Store an accepted sample at the write address.
    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
    end

    // Capture the head entry on an accepted read, otherwise hold the last value.
    always_ff @(posedge clk_i) begin
        if (!rstN_i) begin
            rdData_q <= '0;
        end else if (rdEn_i) begin
            rdData_q <= mem_q[rdAddr_i];
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/filter_data_sink.sv
// Receiving end of the IIR filter output: buffers every valid sample in a
// small FIFO, lets the downstream reader drain it at its own pace, counts
// accepted samples, flags drops and reports completion after end of stream.
module filter_data_sink
    import filter_io_pkg::*;
#(
    parameter int Nb         = NB_DEFAULT,
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [Nb-1:0]    DIN,
    input  logic             VIN,
    input  logic             END_SIM,
    input  logic             RD_EN,
    output logic [Nb-1:0]    DOUT,
    output logic             VOUT,
    output logic             EMPTY,
    output logic             FULL,
    output logic             OVF,
    output logic [CNT_W-1:0] SAMPLE_CNT,
    output logic             DONE
);

    localparam int PTR_W = DEPTH_LOG2 + 1;

    sinkState_e       state_q, state_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             vout_q;
    logic [CNT_W-1:0] sampleCnt_q, sampleCnt_d;
    logic             rdAcc, wrAcc, drop;

    // Accept decisions, control state and next pointer/flag values; the flags
    // are derived from the next pointers so they register alongside them.
    always_comb begin
        state_d     = state_q;
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        ovf_d       = ovf_q;
        sampleCnt_d = sampleCnt_q;
        wrAcc       = 1'b0;
        drop        = 1'b0;
        rdAcc       = RD_EN && !empty_q;

        case (state_q)
            RUN: begin
                wrAcc = VIN && (!full_q || rdAcc);
                drop  = VIN && full_q && !rdAcc;
                if (END_SIM) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (empty_q && !rdAcc) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = FINISH;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (wrAcc) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
            if (sampleCnt_q != '1) begin
                sampleCnt_d = sampleCnt_q + CNT_W'(1);
            end
        end
        if (rdAcc) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        if (drop) begin
            ovf_d = 1'b1;
        end

        empty_d = (wrPtr_d == rdPtr_d);
        full_d  = (wrPtr_d[PTR_W-1] != rdPtr_d[PTR_W-1]) &&
                  (wrPtr_d[PTR_W-2:0] == rdPtr_d[PTR_W-2:0]);
        done_d  = (state_d == FINISH);
    end

    // Control state register.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointers, status flags, counter and read-valid registers.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            vout_q      <= 1'b0;
            sampleCnt_q <= '0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            vout_q      <= rdAcc;
            sampleCnt_q <= sampleCnt_d;
        end
    end

    sink_fifo_mem #(
        .Nb         (Nb),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) uMem (
        .clk_i    (CLK),
        .rstN_i   (RST_n),
        .wrEn_i   (wrAcc),
        .wrAddr_i (wrPtr_q[PTR_W-2:0]),
        .wrData_i (DIN),
        .rdEn_i   (rdAcc),
        .rdAddr_i (rdPtr_q[PTR_W-2:0]),
        .rdData_o (DOUT)
    );

    assign VOUT       = vout_q;
    assign EMPTY      = empty_q;
    assign FULL       = full_q;
    assign OVF        = ovf_q;
    assign SAMPLE_CNT = sampleCnt_q;
    assign DONE       = done_q;

endmodule

// File: tb/tb_filter_data_sink.sv
// Bench for the filter data sink: directed scenarios followed by random
// traffic, every cycle compared against a queue-based model of the sink.
module tb_filter_data_sink;

    localparam int NB      = 10;
    localparam int DL2     = 4;
    localparam int DEPTH   = 1 << DL2;
    localparam int CW      = 5;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RST_n;
    logic [NB-1:0] DIN;
    logic          VIN;
    logic          END_SIM;
    logic          RD_EN;
    logic [NB-1:0] DOUT;
    logic          VOUT;
    logic          EMPTY;
    logic          FULL;
    logic          OVF;
    logic [CW-1:0] SAMPLE_CNT;
    logic          DONE;

    int checks   = 0;
    int failures = 0;

    logic [NB-1:0] modelQ [$];
    logic [NB-1:0] modelDout;
    bit            modelVout;
    bit            modelOvf;
    bit            modelEndSeen;
    bit            modelDone;
    int            modelCnt;

    // Free-running system clock.
    always #5 CLK = ~CLK;

    filter_data_sink #(
        .Nb         (NB),
        .DEPTH_LOG2 (DL2),
        .CNT_W      (CW)
    ) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .DIN        (DIN),
        .VIN        (VIN),
        .END_SIM    (END_SIM),
        .RD_EN      (RD_EN),
        .DOUT       (DOUT),
        .VOUT       (VOUT),
        .EMPTY      (EMPTY),
        .FULL       (FULL),
        .OVF        (OVF),
        .SAMPLE_CNT (SAMPLE_CNT),
        .DONE       (DONE)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the model by one edge, then compare
    // every output shortly after the edge.
    task automatic applyStimulus(input bit rstn, input bit vin,
                                 input logic [NB-1:0] din, input bit rden,
                                 input bit endsim);
        int sizeBefore;
        bit readOk;
        RST_n   = rstn;
        VIN     = vin;
        DIN     = din;
        RD_EN   = rden;
        END_SIM = endsim;

        sizeBefore = modelQ.size();
        if (!rstn) begin
            modelQ.delete();
            modelDout    = '0;
            modelVout    = 1'b0;
            modelOvf     = 1'b0;
            modelCnt     = 0;
            modelEndSeen = 1'b0;
            modelDone    = 1'b0;
        end else begin
            readOk    = rden && (sizeBefore > 0);
            modelDone = modelDone || (modelEndSeen && sizeBefore == 0);
            if (readOk) begin
                modelDout = modelQ.pop_front();
                modelVout = 1'b1;
            end else begin
                modelVout = 1'b0;
            end
            if (!modelEndSeen && vin) begin
                if (sizeBefore < DEPTH || readOk) begin
                    modelQ.push_back(din);
                    if (modelCnt < CNT_MAX) modelCnt++;
                end else begin
                    modelOvf = 1'b1;
                end
            end
            modelEndSeen = modelEndSeen || endsim;
        end

        @(posedge CLK);
        #1;
        checkOutput("VOUT", 32'(VOUT), 32'(modelVout));
        if (modelVout) checkOutput("DOUT", 32'(DOUT), 32'(modelDout));
        checkOutput("EMPTY", 32'(EMPTY), 32'(modelQ.size() == 0));
        checkOutput("FULL", 32'(FULL), 32'(modelQ.size() == DEPTH));
        checkOutput("OVF", 32'(OVF), 32'(modelOvf));
        checkOutput("SAMPLE_CNT", 32'(SAMPLE_CNT), 32'(modelCnt));
        checkOutput("DONE", 32'(DONE), 32'(modelDone));
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic resetCycle();
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    // Directed scenarios then randomized traffic.
    initial begin
        int pv;
        int pr;
        bit rst;
        bit es;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 10'h2A, 1'b1, 1'b0);
        checkOutput("reset_DOUT", 32'(DOUT), 32'h0);
        idleCycle();

        applyStimulus(1'b1, 1'b1, 10'h005, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 10'h3FD, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 10'h1FF, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
        checkOutput("seq_first", 32'(DOUT), 32'h005);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
        checkOutput("seq_second", 32'(DOUT), 32'h3FD);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
        checkOutput("seq_third", 32'(DOUT), 32'h1FF);
        idleCycle();

        resetCycle();
        for (int i = 0; i <= DEPTH; i++) applyStimulus(1'b1, 1'b1, NB'(i), 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
        idleCycle();

        resetCycle();
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b1, NB'(i + 100), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, NB'(i + 200), 1'b1, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);

        resetCycle();
        applyStimulus(1'b1, 1'b1, 10'h007, 1'b1, 1'b0);
        idleCycle();
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
        checkOutput("bypass_read", 32'(DOUT), 32'h007);
        idleCycle();

        resetCycle();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, NB'($urandom), 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, NB'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, NB'($urandom), 1'b0, 1'b0);
        resetCycle();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, NB'($urandom), 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, NB'($urandom), 1'b1, 1'b0);
        resetCycle();
        idleCycle();

        resetCycle();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) idleCycle();

        for (int blk = 0; blk < 15; blk++) begin
            pv = $urandom_range(10, 95);
            pr = $urandom_range(10, 95);
            resetCycle();
            for (int c = 0; c < 200; c++) begin
                rst = ($urandom_range(0, 299) == 0);
                es  = ($urandom_range(0, 149) == 0);
                applyStimulus(!rst, ($urandom_range(0, 99) < pv), NB'($urandom),
                              ($urandom_range(0, 99) < pr), es);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
